// File: rtl/mod_exp.sv
// mod_exp: left-to-right square-and-multiply modular exponentiator,
// result = base^exponent mod n. It drives one external modular multiplier,
// which holds the fixed modulus n, through its operand and restart ports.
// Optional build macro MOD_EXP_SKIP_LEADING_EN: while the accumulator still
// holds its initial value of 1, leading squarings are skipped and the first
// 1 bit loads the base directly. Results are identical either way.
module mod_exp #(
    parameter int WIDTH     = 256,
    parameter int EXP_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 Reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base,
    input  logic [EXP_WIDTH-1:0] exponent,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result,
    output logic                 mul_reset,
    output logic [WIDTH-1:0]     mul_a,
    output logic [WIDTH-1:0]     mul_b,
    input  logic                 mul_done,
    input  logic [WIDTH-1:0]     mul_product
);

    localparam int CNT_W = $clog2(EXP_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQ_START,
        SQ_WAIT,
        MUL_START,
        MUL_WAIT,
        NEXT_BIT,
        FINISH
    } state_t;

    state_t               state_q,   state_d;
    logic [WIDTH-1:0]     acc_q,     acc_d;
    logic [EXP_WIDTH-1:0] e_sh_q,    e_sh_d;
    logic [WIDTH-1:0]     b_reg_q,   b_reg_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;
    logic [WIDTH-1:0]     result_q,  result_d;
    logic [WIDTH-1:0]     mul_a_q,   mul_a_d;
    logic [WIDTH-1:0]     mul_b_q,   mul_b_d;
`ifdef MOD_EXP_SKIP_LEADING_EN
    logic                 one_acc_q, one_acc_d;
`endif

    // Next-state and datapath updates for the square-and-multiply sequencer.
    always_comb begin
        // NOTE: every _d signal gets a default first so no path infers a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        e_sh_d    = e_sh_q;
        b_reg_d   = b_reg_q;
        bit_cnt_d = bit_cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        result_d  = result_q;
        mul_a_d   = mul_a_q;
        mul_b_d   = mul_b_q;
`ifdef MOD_EXP_SKIP_LEADING_EN
        one_acc_d = one_acc_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    b_reg_d   = base;
                    e_sh_d    = exponent;
                    acc_d     = WIDTH'(1);
                    bit_cnt_d = CNT_W'(EXP_WIDTH);
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
`ifdef MOD_EXP_SKIP_LEADING_EN
                    one_acc_d = 1'b1;
`endif
                    state_d   = LOAD;
                end
            end

            LOAD: begin
`ifdef MOD_EXP_SKIP_LEADING_EN
                state_d = one_acc_q ? NEXT_BIT : SQ_START;
`else
                state_d = SQ_START;
`endif
            end

            // Operands are registered here and stay stable through the wait,
            // since the multiplier reads them live once it leaves Init.
            SQ_START: begin
                mul_a_d = acc_q;
                mul_b_d = acc_q;
                state_d = SQ_WAIT;
            end

            SQ_WAIT: begin
                if (mul_done) begin
                    acc_d   = mul_product;
                    state_d = e_sh_q[EXP_WIDTH-1] ? MUL_START : NEXT_BIT;
                end
            end

            MUL_START: begin
                mul_a_d = acc_q;
                mul_b_d = b_reg_q;
                state_d = MUL_WAIT;
            end

            MUL_WAIT: begin
                if (mul_done) begin
                    acc_d   = mul_product;
                    state_d = NEXT_BIT;
                end
            end

            NEXT_BIT: begin
`ifdef MOD_EXP_SKIP_LEADING_EN
                // While acc is still 1, squaring is a no-op and a 1 bit
                // simply makes acc equal to the base.
                if (one_acc_q && e_sh_q[EXP_WIDTH-1]) begin
                    acc_d     = b_reg_q;
                    one_acc_d = 1'b0;
                end
`endif
                e_sh_d    = e_sh_q << 1;
                bit_cnt_d = bit_cnt_q - CNT_W'(1);
                if (bit_cnt_d == '0) begin
                    state_d = FINISH;
                end else begin
`ifdef MOD_EXP_SKIP_LEADING_EN
                    state_d = one_acc_d ? NEXT_BIT : SQ_START;
`else
                    state_d = SQ_START;
`endif
                end
            end

            FINISH: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (Reset) begin
            state_q   <= IDLE;
            acc_q     <= WIDTH'(1);
            e_sh_q    <= '0;
            b_reg_q   <= '0;
            bit_cnt_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            mul_a_q   <= '0;
            mul_b_q   <= '0;
`ifdef MOD_EXP_SKIP_LEADING_EN
            one_acc_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            e_sh_q    <= e_sh_d;
            b_reg_q   <= b_reg_d;
            bit_cnt_q <= bit_cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            mul_a_q   <= mul_a_d;
            mul_b_q   <= mul_b_d;
`ifdef MOD_EXP_SKIP_LEADING_EN
            one_acc_q <= one_acc_d;
`endif
        end
    end

    // The multiplier is held in Init during Reset and restarted for exactly
    // one cycle per launch.
    assign mul_reset = Reset || (state_q == SQ_START) || (state_q == MUL_START);

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign mul_a  = mul_a_q;
    assign mul_b  = mul_b_q;

endmodule

// File: tb/tb_mod_exp.sv
// tb_mod_exp: drives mod_exp with directed and random operations against a
// behavioural modular multiplier (random 3-40 cycle latency, Done held high).
// Expected results and launch counts go into a scoreboard queue; a separate
// monitor pops and compares them on each rising done.
module tb_mod_exp;

    localparam int W      = 256;
    localparam int EW     = 256;
    localparam int BUDGET = 25000;
    localparam logic [W-1:0] N_MOD =
        256'hffffffff00000001000000000000000000000000ffffffffffffffffffffffff;

    logic          clk;
    logic          reset;
    logic          start;
    logic [W-1:0]  base;
    logic [EW-1:0] exponent;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          mul_reset;
    logic [W-1:0]  mul_a;
    logic [W-1:0]  mul_b;
    logic          mul_done;
    logic [W-1:0]  mul_product;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_res_q[$];
    int           exp_launch_q[$];

    mod_exp #(.WIDTH(W), .EXP_WIDTH(EW)) dut (
        .clk        (clk),
        .Reset      (reset),
        .start      (start),
        .base       (base),
        .exponent   (exponent),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .mul_reset  (mul_reset),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_done   (mul_done),
        .mul_product(mul_product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        p = p % {{W{1'b0}}, N_MOD};
        return p[W-1:0];
    endfunction

    // Reference power, right-to-left binary method.
    function automatic logic [W-1:0] pow_ref(input logic [W-1:0] b_in, input logic [EW-1:0] e_in);
        logic [W-1:0] r;
        logic [W-1:0] sq;
        r  = W'(1);
        sq = b_in;
        for (int i = 0; i < EW; i++) begin
            if (e_in[i]) r = mulmod(r, sq);
            sq = mulmod(sq, sq);
        end
        return r;
    endfunction

    function automatic int launches_ref(input logic [EW-1:0] e_in);
        int bitlen;
        int pop;
        bitlen = 0;
        pop    = $countones(e_in);
        for (int i = 0; i < EW; i++) if (e_in[i]) bitlen = i + 1;
`ifdef MOD_EXP_SKIP_LEADING_EN
        return (e_in == '0) ? 0 : (bitlen - 1) + (pop - 1);
`else
        return EW + pop;
`endif
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Behavioural multiplier: Init while mul_reset, then random latency,
    // product of the live operands, Done held until the next restart.
    int mul_cnt = 0;
    always @(posedge clk) begin
        if (mul_reset) begin
            mul_cnt  <= $urandom_range(40, 3);
            mul_done <= 1'b0;
        end else if (mul_cnt > 1) begin
            mul_cnt <= mul_cnt - 1;
        end else if (mul_cnt == 1) begin
            mul_cnt     <= 0;
            mul_done    <= 1'b1;
            mul_product <= mulmod(mul_a, mul_b);
        end
    end

    // Monitor: counts launches and scores each completed operation.
    initial begin
        int           launch_cnt;
        logic         done_prev;
        logic [W-1:0] r_exp;
        int           l_exp;
        launch_cnt = 0;
        done_prev  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                launch_cnt = 0;
                done_prev  = 1'b0;
            end else begin
                if (mul_reset) launch_cnt++;
                if (done && !done_prev) begin
                    if (exp_res_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected done: got result %h with empty scoreboard", result);
                    end else begin
                        r_exp = exp_res_q.pop_front();
                        l_exp = exp_launch_q.pop_front();
                        check("result", result, r_exp);
                        check("launches", W'(launch_cnt), W'(l_exp));
                    end
                    launch_cnt = 0;
                end
                done_prev = done;
            end
        end
    end

    // Called at a negedge; start is accepted at the following posedge.
    task automatic issue(input logic [W-1:0] b_in, input logic [EW-1:0] e_in, input bit push);
        start    = 1'b1;
        base     = b_in;
        exponent = e_in;
        if (push) begin
            exp_res_q.push_back(pow_ref(b_in, e_in));
            exp_launch_q.push_back(launches_ref(e_in));
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < BUDGET) begin
            @(negedge clk);
            n++;
        end
        check({name, " done"}, W'(done), W'(1));
    endtask

    initial begin
        logic [W-1:0]  rb;
        logic [EW-1:0] re;
        int            n;
        int            target;

        reset    = 1'b1;
        start    = 1'b0;
        base     = '0;
        exponent = '0;
        repeat (3) @(negedge clk);
        check("mul_reset during reset", W'(mul_reset), W'(1));
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", W'(busy), W'(0));
        check("reset done", W'(done), W'(0));
        check("reset result", result, W'(0));
        check("reset mul_a", mul_a, W'(0));
        check("reset mul_b", mul_b, W'(0));
        check("idle mul_reset", W'(mul_reset), W'(0));

        // 2^10 and done held in Idle.
        issue(W'(2), EW'(10), 1'b1);
        check("busy after accept", W'(busy), W'(1));
        wait_done("2^10");
        repeat (3) @(negedge clk);
        check("done held", W'(done), W'(1));
        check("held result", result, W'(1024));
        check("idle busy", W'(busy), W'(0));

        // Zero exponent.
        issue(W'(5), EW'(0), 1'b1);
        wait_done("5^0");
        check("5^0 result", result, W'(1));

        // (n-1)^2 = 1.
        issue(N_MOD - W'(1), EW'(2), 1'b1);
        wait_done("(n-1)^2");

        // Fermat inverse of 3.
        issue(W'(3), N_MOD - W'(2), 1'b1);
        wait_done("3^(n-2)");
        check("inverse of 3", mulmod(result, W'(3)), W'(1));

        // start re-pulsed while busy with different inputs is ignored.
        issue(W'(11), EW'(32'h1234_5678), 1'b1);
        repeat (20) @(negedge clk);
        issue(W'(7), EW'(5), 1'b0);
        wait_done("re-pulse");

        // Back-to-back start in the first cycle done is visible.
        issue(W'(13), EW'(24'habcdef), 1'b1);
        check("done dropped on accept", W'(done), W'(0));
        check("busy on back-to-back", W'(busy), W'(1));
        wait_done("back-to-back");

        // Reset around bit 100 of an all-ones exponent.
`ifdef MOD_EXP_SKIP_LEADING_EN
        target = 198;
`else
        target = 200;
`endif
        issue(W'(9), '1, 1'b0);
        n = 0;
        begin
            int launches;
            launches = 0;
            while (launches < target && n < BUDGET) begin
                if (mul_reset) launches++;
                @(negedge clk);
                n++;
            end
            check("reached bit 100", W'(launches), W'(target));
        end
        reset = 1'b1;
        @(negedge clk);
        check("abort busy", W'(busy), W'(0));
        check("abort done", W'(done), W'(0));
        check("abort mul_reset", W'(mul_reset), W'(1));
        reset = 1'b0;
        @(negedge clk);
        check("post-abort busy", W'(busy), W'(0));

        issue(W'(3), EW'(3), 1'b1);
        wait_done("3^3");
        check("3^3 result", result, W'(27));

        // Random operations: one full-width, one short exponent.
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 8; j++) begin
                rb[j*32 +: 32] = $urandom;
                re[j*32 +: 32] = $urandom;
            end
            rb = rb % N_MOD;
            if (k == 1) re = re & ((EW'(1) << $urandom_range(40, 1)) - EW'(1));
            issue(rb, re, 1'b1);
            wait_done("random");
        end

        @(negedge clk);
        check("scoreboard drained", W'(exp_res_q.size()), W'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mod_exp.md
Name: mod_exp

Overview:
- Modular exponentiator: computes result = base^exponent mod n by left-to-right square-and-multiply.
- n is the fixed curve modulus params.n, the same modulus the multiplier uses.
- Sits directly upstream of one external modular multiplier instance and drives its operand/restart ports.
- Consumers: the field-inversion path (Fermat, exponent n-2) and other power operations.

Parameters:
- WIDTH, 256, operand/result width; must match the multiplier.
- EXP_WIDTH, 256, exponent width; bits are scanned MSB first.

Ports:
- clk  input  1  clock
- Reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in Idle
- base  input  WIDTH  base operand; caller guarantees base < n
- exponent  input  EXP_WIDTH  exponent
- busy  output  1  operation in progress
- done  output  1  result valid; held until the next accepted start or Reset
- result  output  WIDTH  base^exponent mod n
- mul_reset  output  1  restart pulse to the multiplier's Reset
- mul_a  output  WIDTH  multiplier operand a
- mul_b  output  WIDTH  multiplier operand b
- mul_done  input  1  multiplier Done
- mul_product  input  WIDTH  multiplier product

Behaviour:
- Reset values: busy=0, done=0, result=0, mul_a=0, mul_b=0, state=Idle. mul_reset=1 while Reset is high, so the multiplier is held in Init.
- Registers:
  - acc (WIDTH), initialised to 1
  - e_sh (EXP_WIDTH), the latched exponent, shifted left once per bit
  - b_reg (WIDTH), the latched base
  - bit_cnt, ceil(log2(EXP_WIDTH+1)) bits
- States: Idle, Load, SqStart, SqWait, MulStart, MulWait, NextBit, Finish.
- Idle: on start=1, latch base/exponent, set acc=1, set bit_cnt=EXP_WIDTH, clear done, go to Load.
- Load: busy=1; go to SqStart.
- SqStart:
  - mul_a=acc, mul_b=acc, mul_reset=1 for exactly this cycle.
  - Go to SqWait.
- SqWait:
  - Hold mul_a/mul_b stable, because the multiplier reads a[0] live after Init.
  - On mul_done=1: acc<=mul_product.
  - If e_sh[MSB]=1, go to MulStart; else go to NextBit.
- MulStart: mul_a=acc, mul_b=b_reg, mul_reset=1 for one cycle; go to MulWait.
- MulWait: hold operands; on mul_done=1, acc<=mul_product and go to NextBit.
- NextBit:
  - e_sh<<=1, bit_cnt-=1.
  - If the decremented count is 0, go to Finish; else go to SqStart.
- Finish: result<=acc, done=1, busy=0; go to Idle. done stays high in Idle until start is accepted.
- mul_done is sampled only in SqWait/MulWait. The multiplier is in Init during the first wait cycle, so a stale Done from a previous operation cannot be observed.
- mul_reset = Reset OR (state is SqStart or MulStart).
- start while busy is ignored; inputs are not re-latched.
- exponent=0 gives result 1: EXP_WIDTH squarings of 1 are performed.
- Reset mid-operation: return to Idle next cycle, drop busy/done, multiplier restarted; no result is written.
- Latency: 2 + per-bit (1 + Tmul) for the square + (1 + Tmul) for the multiply when the bit is 1 + 1 for NextBit, plus 1 for Finish. Tmul is the multiplier latency measured from the cycle after its reset.
- Multiplier launches per operation: EXP_WIDTH squares plus popcount(exponent) multiplies.

Optional Feature:
- Macro MOD_EXP_SKIP_LEADING_EN.
- Defined: a flag one_acc stays set while acc is still the initial 1.
  - While one_acc is set, SqStart/SqWait are bypassed.
  - A 1 bit sets acc<=b_reg directly, with no multiplier launch, and clears one_acc.
  - Launches become (bitlen-1) squares + (popcount-1) multiplies, where bitlen = position of highest set bit + 1.
  - exponent=0 finishes after EXP_WIDTH NextBit cycles with result 1 and zero launches.
- Undefined: plain schedule as above.
- Results are identical either way.

Test Plan:
- Bench uses a behavioural multiplier model with random 3-40 cycle latency and Done held high after completion.
- base=2, exponent=10 -> result=1024, done=1. Launches: 258 without the macro; 4 (3 squares, 1 multiply) with it.
- base=5, exponent=0 -> result=1; with the macro, zero mul_reset pulses.
- base=n-1, exponent=2 -> result=1. base=3, exponent=n-2 -> result*3 mod n = 1, checked against a software model.
- start re-pulsed while busy with base=7 -> ignored; the original result is returned. Back-to-back start in the cycle after done -> accepted, and done drops.
- Reset asserted at bit 100 of exponent=0xFF..FF -> busy=0, done=0 next cycle. A new start with base=3, exponent=3 -> result=27.
